// File: rtl/m_memarb_pkg.sv
// Shared definitions for the m_memarb single-port memory arbiter.
// Optional round-robin contention mode: MEMARB_RR_EN.
package m_memarb_pkg;

    localparam int unsigned MEMARB_ADDR_W     = 12;
    localparam int unsigned MEMARB_DATA_W     = 32;
    localparam int unsigned MEMARB_STARVE_MAX = 4;

    // Response FSM encodings, kept as plain constants for legacy compatibility
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RI   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    // Requester IDs (stored in the last-grant pointer)
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/m_memarb_pick.sv
// Combinational grant selection for m_memarb.
// MEMARB_RR_EN selects round-robin contention; otherwise fixed data priority with starvation guard.
module m_memarb_pick
    import m_memarb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = MEMARB_STARVE_MAX,
    parameter int unsigned STARVE_W   = 3
) (
    input  logic                hold_i,
    input  logic                ireq_i,
    input  logic                dreq_i,
`ifdef MEMARB_RR_EN
    input  logic                last_i,
`else
    input  logic [STARVE_W-1:0] dstreak_i,
`endif
    output logic                igrant_o,
    output logic                dgrant_o
);

    logic ifavor;

    always_comb begin
`ifdef MEMARB_RR_EN
        ifavor = (last_i == REQ_D);
`else
        ifavor = (dstreak_i == STARVE_W'(STARVE_MAX));
`endif
        igrant_o = 1'b0;
        dgrant_o = 1'b0;
        if (!hold_i) begin
            if (ireq_i && (!dreq_i || ifavor)) begin
                igrant_o = 1'b1;
            end else if (dreq_i) begin
                dgrant_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_memarb.sv
// Single-port memory arbiter: instruction fetch vs. data access, 1-cycle read latency.
// Optional round-robin contention mode: MEMARB_RR_EN.
module m_memarb
    import m_memarb_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEMARB_ADDR_W,
    parameter int unsigned DATA_W     = MEMARB_DATA_W,
    parameter int unsigned STARVE_MAX = MEMARB_STARVE_MAX
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_hold,
    input  logic              w_ireq,
    input  logic [ADDR_W-1:0] w_iaddr,
    output logic              w_igrant,
    output logic              r_ivalid,
    output logic [DATA_W-1:0] w_idata,
    input  logic              w_dreq,
    input  logic              w_dwe,
    input  logic [ADDR_W-1:0] w_daddr,
    input  logic [DATA_W-1:0] w_ddin,
    output logic              w_dgrant,
    output logic              r_dvalid,
    output logic [DATA_W-1:0] w_ddata,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [DATA_W-1:0] w_mdin,
    input  logic [DATA_W-1:0] w_mdout
);

    logic [1:0] state_q, state_d;

`ifdef MEMARB_RR_EN
    logic last_q, last_d;

    m_memarb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (1)
    ) u_pick (
        .hold_i   (w_hold),
        .ireq_i   (w_ireq),
        .dreq_i   (w_dreq),
        .last_i   (last_q),
        .igrant_o (w_igrant),
        .dgrant_o (w_dgrant)
    );

    always_comb begin
        last_d = last_q;
        if (w_igrant) begin
            last_d = REQ_I;
        end else if (w_dgrant) begin
            last_d = REQ_D;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] dstreak_q, dstreak_d;

    m_memarb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .hold_i    (w_hold),
        .ireq_i    (w_ireq),
        .dreq_i    (w_dreq),
        .dstreak_i (dstreak_q),
        .igrant_o  (w_igrant),
        .dgrant_o  (w_dgrant)
    );

    // Streak counts contested data grants; a held cycle leaves it frozen.
    always_comb begin
        dstreak_d = dstreak_q;
        if (!w_hold) begin
            if (w_dgrant && w_ireq) begin
                if (dstreak_q != STARVE_W'(STARVE_MAX)) begin
                    dstreak_d = dstreak_q + 1'b1;
                end
            end else begin
                dstreak_d = '0;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            dstreak_q <= '0;
        end else begin
            dstreak_q <= dstreak_d;
        end
    end
`endif

    always_comb begin
        w_maddr = '0;
        w_mwe   = 1'b0;
        state_d = S_IDLE;
        if (w_dgrant) begin
            w_maddr = w_daddr;
            w_mwe   = w_dwe;
            state_d = w_dwe ? S_IDLE : S_RD;
        end else if (w_igrant) begin
            w_maddr = w_iaddr;
            state_d = S_RI;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign r_ivalid = (state_q == S_RI);
    assign r_dvalid = (state_q == S_RD);
    assign w_idata  = w_mdout;
    assign w_ddata  = w_mdout;
    assign w_mdin   = w_ddin;

endmodule

// File: tb/tb_m_memarb.sv
// Directed self-checking bench for m_memarb with a behavioural synchronous-read memory.
// Build with MEMARB_RR_EN defined to check the round-robin grant sequence.
module tb_m_memarb;
    import m_memarb_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          igrant;
    logic          ivalid;
    logic [DW-1:0] idata;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddin;
    logic          dgrant;
    logic          dvalid;
    logic [DW-1:0] ddata;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [DW-1:0] mdin;
    logic [DW-1:0] mdout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    m_memarb #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .w_clk    (clk),
        .w_rst_n  (rst_n),
        .w_hold   (hold),
        .w_ireq   (ireq),
        .w_iaddr  (iaddr),
        .w_igrant (igrant),
        .r_ivalid (ivalid),
        .w_idata  (idata),
        .w_dreq   (dreq),
        .w_dwe    (dwe),
        .w_daddr  (daddr),
        .w_ddin   (ddin),
        .w_dgrant (dgrant),
        .r_dvalid (dvalid),
        .w_ddata  (ddata),
        .w_maddr  (maddr),
        .w_mwe    (mwe),
        .w_mdin   (mdin),
        .w_mdout  (mdout)
    );

    always @(posedge clk) begin
        if (mwe) mem[maddr] <= mdin;
        mdout <= mem[maddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        string seq;
        logic  pi;
        logic  pd;

`ifdef MEMARB_RR_EN
        seq = "IDIHDIDIDIDI";
`else
        seq = "DDDHDIDDDDID";
`endif
        rst_n = 1'b0; hold = 1'b0; ireq = 1'b0; iaddr = '0;
        dreq = 1'b0; dwe = 1'b0; daddr = '0; ddin = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ivalid", 32'(ivalid), 0);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_igrant", 32'(igrant), 0);
        check("rst_dgrant", 32'(dgrant), 0);
        check("rst_maddr", 32'(maddr), 0);
        check("rst_mwe", 32'(mwe), 0);
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));

        @(negedge clk);
        rst_n = 1'b1;
        // preload mem[5] through the data port
        dreq = 1'b1; dwe = 1'b1; daddr = 12'd5; ddin = 32'h1234;
        #1;
        check("pre_dgrant", 32'(dgrant), 1);
        check("pre_mwe", 32'(mwe), 1);
        check("pre_maddr", 32'(maddr), 5);
        check("pre_mdin", mdin, 32'h1234);
        @(negedge clk);
        dreq = 1'b0; dwe = 1'b0;
        #1;
        check("pre_novalid", 32'(dvalid), 0);

        ireq = 1'b1; iaddr = 12'd5;
        #1;
        check("i_igrant", 32'(igrant), 1);
        check("i_dgrant", 32'(dgrant), 0);
        check("i_maddr", 32'(maddr), 5);
        check("i_mwe", 32'(mwe), 0);
        @(negedge clk);
        ireq = 1'b0;
        #1;
        check("i_ivalid", 32'(ivalid), 1);
        check("i_idata", idata, 32'h1234);
        check("i_dvalid", 32'(dvalid), 0);

        dreq = 1'b1; dwe = 1'b1; daddr = 12'd9; ddin = 32'hCAFE;
        #1;
        check("w_dgrant", 32'(dgrant), 1);
        check("w_mwe", 32'(mwe), 1);
        check("w_maddr", 32'(maddr), 9);
        @(negedge clk);
        dwe = 1'b0;
        #1;
        check("w_novalid", 32'(dvalid), 0);
        check("r_dgrant", 32'(dgrant), 1);
        check("r_mwe", 32'(mwe), 0);
        @(negedge clk);
        dreq = 1'b0;
        #1;
        check("r_dvalid", 32'(dvalid), 1);
        check("r_ddata", ddata, 32'hCAFE);

        @(negedge clk);
        ireq = 1'b1; dreq = 1'b1; iaddr = 12'd5; daddr = 12'd9; dwe = 1'b0;
        pi = 1'b0; pd = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (seq[c] == "H") begin
                hold = 1'b1; dwe = 1'b1; ddin = 32'hDEAD;
            end
            #1;
            check($sformatf("c%0d_igrant", c), 32'(igrant), 32'(seq[c] == "I"));
            check($sformatf("c%0d_dgrant", c), 32'(dgrant), 32'(seq[c] == "D"));
            check($sformatf("c%0d_mwe", c), 32'(mwe), 0);
            check($sformatf("c%0d_ivalid", c), 32'(ivalid), 32'(pi));
            check($sformatf("c%0d_dvalid", c), 32'(dvalid), 32'(pd));
            if (pi) check($sformatf("c%0d_idata", c), idata, 32'h1234);
            if (pd) check($sformatf("c%0d_ddata", c), ddata, 32'hCAFE);
            pi = (seq[c] == "I");
            pd = (seq[c] == "D");
            @(negedge clk);
            hold = 1'b0; dwe = 1'b0;
        end
        ireq = 1'b0; dreq = 1'b0;
        #1;
        check("c_end_ivalid", 32'(ivalid), 32'(pi));
        check("c_end_dvalid", 32'(dvalid), 32'(pd));

        // reset lands on the edge that would have produced the read response
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b0; daddr = 12'd9;
        #1;
        check("rr_dgrant", 32'(dgrant), 1);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        dreq = 1'b0;
        check("rr_dvalid", 32'(dvalid), 0);
        check("rr_state", 32'(dut.state_q), 32'(S_IDLE));
        @(negedge clk);
        check("rr_dvalid2", 32'(dvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b0; daddr = 12'd9;
        #1;
        check("post_dgrant", 32'(dgrant), 1);
        @(negedge clk);
        dreq = 1'b0;
        #1;
        check("post_dvalid", 32'(dvalid), 1);
        check("post_ddata", ddata, 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
